cal_core_scheduler: RTL and testbench

CAL_CORE_SCHEDULER -- requirements
Module: cal_core_scheduler

---
 rtl/cal_core_pkg.sv | 11 +
 rtl/cal_sched_watchdog.sv | 17 +
 rtl/cal_core_scheduler.sv | 143 ++++++++++++++
 tb/tb_cal_core_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_core_pkg.sv
// cal_core_pkg: shared FSM state encoding, counter width helpers and watchdog default
package cal_core_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_H, S_SEND_A, S_WAIT_BETA, S_DONE} state_t;
  localparam int TIMEOUT_DEF = 4096;
  function automatic int row_w(input int i);
    return $clog2(i) + 1;
  endfunction
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cal_sched_watchdog.sv
// cal_sched_watchdog: counts idle cycles while run is high; kick restarts the count
module cal_sched_watchdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!run || kick) ? '0 : cnt + CW'(1);
  assign expired = run && !kick && cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/cal_core_scheduler.sv
// cal_core_scheduler: feeds H rows and alpha_u columns to the core and tags returned beta.
// Define CAL_SCHED_TIMEOUT_EN to build the WAIT_BETA watchdog.
module cal_core_scheduler
  import cal_core_pkg::*;
#(
  parameter int J            = 14,
  parameter int I            = 7,
  parameter int A            = 2,
  parameter int BETA_PER_ROW = 1,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [row_w(I)-1:0]   cfg_rows,
  input  logic [J-1:0]          h_in,
  input  logic                  h_in_valid,
  output logic                  h_in_ready,
  input  logic [J*8-1:0]        alpha_in,
  input  logic                  alpha_in_valid,
  output logic                  alpha_in_ready,
  output logic [J-1:0]          core_H_row,
  output logic                  core_H_row_tvalid,
  output logic [J*8-1:0]        core_alpha,
  output logic                  core_alpha_tvalid,
  output logic                  core_alpha_tlast,
  input  logic [A*8-1:0]        core_beta,
  input  logic                  core_beta_tvalid,
  output logic [A*8-1:0]        beta_out,
  output logic                  beta_out_valid,
  output logic [row_w(I)-1:0]   beta_out_row,
  output logic                  beta_out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  spurious_beta
);
  localparam int RW = row_w(I);
  localparam int AW = cnt_w(A);
  localparam int BW = cnt_w(BETA_PER_ROW);
  if (A < 1 || BETA_PER_ROW < 1 || I < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("cal_core_scheduler: parameters must be positive");
  end
  state_t state, nxt;
  logic [RW-1:0] rows, row_idx;
  logic [AW-1:0] a_cnt;
  logic [BW-1:0] beat_cnt;
  logic h_acc, a_acc, b_acc, a_last, row_end, frame_end, go, to;
  assign busy           = state != S_IDLE;
  assign h_in_ready     = state == S_LOAD_H && !abort;
  assign alpha_in_ready = state == S_SEND_A && !abort;
  assign h_acc          = h_in_ready && h_in_valid;
  assign a_acc          = alpha_in_ready && alpha_in_valid;
  assign b_acc          = state == S_WAIT_BETA && core_beta_tvalid && !abort;
  assign a_last         = a_cnt == AW'(A - 1);
  assign row_end        = b_acc && beat_cnt == BW'(BETA_PER_ROW - 1);
  assign frame_end      = row_end && row_idx == rows - RW'(1);
  assign go             = state == S_IDLE && start && !abort;
`ifdef CAL_SCHED_TIMEOUT_EN
  cal_sched_watchdog #(.LIMIT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == S_WAIT_BETA),
    .kick    (core_beta_tvalid),
    .expired (to)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timeout_err <= 1'b0;
    else if (to && !abort) timeout_err <= 1'b1;
    else if (go) timeout_err <= 1'b0;
`else
  assign to          = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:      nxt = start ? S_LOAD_H : S_IDLE;
      S_LOAD_H:    nxt = h_acc ? S_SEND_A : S_LOAD_H;
      S_SEND_A:    nxt = (a_acc && a_last) ? S_WAIT_BETA : S_SEND_A;
      S_WAIT_BETA: nxt = frame_end ? S_DONE : row_end ? S_LOAD_H : to ? S_IDLE : S_WAIT_BETA;
      S_DONE:      nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end
  // Output pulses are registered from the accept strobes, which are already gated by abort
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      core_H_row        <= '0;
      core_H_row_tvalid <= 1'b0;
      core_alpha        <= '0;
      core_alpha_tvalid <= 1'b0;
      core_alpha_tlast  <= 1'b0;
      beta_out          <= '0;
      beta_out_valid    <= 1'b0;
      beta_out_row      <= '0;
      beta_out_last     <= 1'b0;
      done              <= 1'b0;
    end else begin
      core_H_row_tvalid <= h_acc;
      core_alpha_tvalid <= a_acc;
      core_alpha_tlast  <= a_acc && a_last;
      beta_out_valid    <= b_acc;
      beta_out_last     <= frame_end;
      done              <= state == S_DONE && !abort;
      if (h_acc) core_H_row <= h_in;
      if (a_acc) core_alpha <= alpha_in;
      if (b_acc) begin
        beta_out     <= core_beta;
        beta_out_row <= row_idx;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rows     <= '0;
      row_idx  <= '0;
      a_cnt    <= '0;
      beat_cnt <= '0;
    end else if (abort) begin
      row_idx  <= '0;
      a_cnt    <= '0;
      beat_cnt <= '0;
    end else if (go) begin
      rows     <= (cfg_rows == '0 || cfg_rows > RW'(I)) ? RW'(I) : cfg_rows;
      row_idx  <= '0;
      a_cnt    <= '0;
      beat_cnt <= '0;
    end else begin
      if (a_acc) a_cnt <= a_last ? '0 : a_cnt + AW'(1);
      if (b_acc) beat_cnt <= row_end ? '0 : beat_cnt + BW'(1);
      if (row_end && !frame_end) row_idx <= row_idx + RW'(1);
    end
  // A set in the same cycle as the clearing start still wins, so no stray beat is hidden
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) spurious_beta <= 1'b0;
    else if (core_beta_tvalid && state != S_WAIT_BETA) spurious_beta <= 1'b1;
    else if (go) spurious_beta <= 1'b0;
endmodule

// File: tb/tb_cal_core_scheduler.sv
// tb_cal_core_scheduler: table-driven frames plus directed abort/spurious/reset/timeout sequences
module tb_cal_core_scheduler;
  localparam int J = 14, I = 7, A = 2, BPR = 1, TO = 16;
  localparam int RW = $clog2(I) + 1, JW = J * 8, BWD = A * 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [RW-1:0] cfg_rows = '0;
  logic [J-1:0] h_in = '0;
  logic h_in_valid = 1'b0, h_in_ready;
  logic [JW-1:0] alpha_in = '0;
  logic alpha_in_valid = 1'b0, alpha_in_ready;
  logic [J-1:0] core_H_row;
  logic core_H_row_tvalid;
  logic [JW-1:0] core_alpha;
  logic core_alpha_tvalid, core_alpha_tlast;
  logic [BWD-1:0] core_beta = '0;
  logic core_beta_tvalid = 1'b0;
  logic [BWD-1:0] beta_out;
  logic beta_out_valid, beta_out_last;
  logic [RW-1:0] beta_out_row;
  logic busy, done, timeout_err, spurious_beta;
  int compared = 0, mismatched = 0;
  int mh, ma, mb, tl, dc, exp_rows;
  logic prev_last = 1'b0;
  typedef struct {
    int cfg;
    bit gap;
    bit noisy;
    int rows;
  } vec_t;
  vec_t vecs[7];
  cal_core_scheduler #(.J(J), .I(I), .A(A), .BETA_PER_ROW(BPR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_rows(cfg_rows),
    .h_in(h_in), .h_in_valid(h_in_valid), .h_in_ready(h_in_ready),
    .alpha_in(alpha_in), .alpha_in_valid(alpha_in_valid), .alpha_in_ready(alpha_in_ready),
    .core_H_row(core_H_row), .core_H_row_tvalid(core_H_row_tvalid),
    .core_alpha(core_alpha), .core_alpha_tvalid(core_alpha_tvalid), .core_alpha_tlast(core_alpha_tlast),
    .core_beta(core_beta), .core_beta_tvalid(core_beta_tvalid),
    .beta_out(beta_out), .beta_out_valid(beta_out_valid), .beta_out_row(beta_out_row),
    .beta_out_last(beta_out_last), .busy(busy), .done(done), .timeout_err(timeout_err),
    .spurious_beta(spurious_beta)
  );
  always #5 clk = ~clk;
  function automatic logic [J-1:0] h_val(int k);
    return J'(k * 13 + 5);
  endfunction
  function automatic logic [JW-1:0] a_val(int k);
    logic [7:0] b;
    b = 8'(k * 7 + 1);
    return {J{b}};
  endfunction
  function automatic logic [BWD-1:0] b_val(int k);
    return BWD'(k * 257 + 3);
  endfunction
  task automatic chk(string n, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_mon(int rows);
    exp_rows = rows;
    mh = 0; ma = 0; mb = 0; tl = 0; dc = 0;
  endtask
  always @(negedge clk) if (rst_n) begin
    if (core_H_row_tvalid) begin
      chk("h_row", 128'(core_H_row), 128'(h_val(mh)));
      mh++;
    end
    if (core_alpha_tvalid) begin
      chk("alpha", 128'(core_alpha), 128'(a_val(ma)));
      chk("tlast", 128'(core_alpha_tlast), 128'((ma % A) == A - 1));
      ma++;
    end
    if (core_alpha_tlast) tl++;
    if (beta_out_valid) begin
      chk("beta", 128'(beta_out), 128'(b_val(mb)));
      chk("beta_row", 128'(beta_out_row), 128'(mb / BPR));
      chk("beta_last", 128'(beta_out_last), 128'(mb == exp_rows * BPR - 1));
      mb++;
    end
    if (done) begin
      dc++;
      chk("done_after_last", 128'(prev_last), 128'(1));
    end
    prev_last = beta_out_last;
  end
  task automatic send_h(int k);
    bit acc = 0;
    int n = 0;
    h_in = h_val(k);
    h_in_valid = 1'b1;
    while (!acc && n < 50) begin
      acc = h_in_ready;
      tick();
      n++;
    end
    h_in_valid = 1'b0;
    chk("h_accept", 128'(acc), 128'(1));
  endtask
  task automatic send_a(int k);
    bit acc = 0;
    int n = 0;
    alpha_in = a_val(k);
    alpha_in_valid = 1'b1;
    while (!acc && n < 50) begin
      acc = alpha_in_ready;
      tick();
      n++;
    end
    alpha_in_valid = 1'b0;
    chk("a_accept", 128'(acc), 128'(1));
  endtask
  task automatic run_frame(int cfg, bit gap, bit noisy, int rows);
    int n = 0;
    clr_mon(rows);
    cfg_rows = RW'(cfg);
    start = 1'b1;
    tick();
    if (noisy) cfg_rows = RW'(3);
    else start = 1'b0;
    chk("busy_start", 128'(busy), 128'(1));
    for (int r = 0; r < rows; r++) begin
      send_h(r);
      for (int b = 0; b < A; b++) begin
        if (gap) begin
          alpha_in_valid = 1'b0;
          tick();
        end
        send_a(r * A + b);
      end
      for (int k = 0; k < BPR; k++) begin
        core_beta = b_val(r * BPR + k);
        core_beta_tvalid = 1'b1;
        tick();
        core_beta_tvalid = 1'b0;
      end
    end
    start = 1'b0;
    while (dc == 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk("frame_h", 128'(mh), 128'(rows));
    chk("frame_alpha", 128'(ma), 128'(rows * A));
    chk("frame_tlast", 128'(tl), 128'(rows));
    chk("frame_beta", 128'(mb), 128'(rows * BPR));
    chk("frame_done", 128'(dc), 128'(1));
    chk("frame_idle", 128'(busy), 128'(0));
  endtask
  initial begin
    #400000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{cfg: 2, gap: 0, noisy: 0, rows: 2};
    vecs[1] = '{cfg: 0, gap: 0, noisy: 0, rows: 7};
    vecs[2] = '{cfg: 2, gap: 1, noisy: 0, rows: 2};
    vecs[3] = '{cfg: 5, gap: 0, noisy: 0, rows: 5};
    vecs[4] = '{cfg: 9, gap: 1, noisy: 0, rows: 7};
    vecs[5] = '{cfg: 1, gap: 0, noisy: 1, rows: 1};
    vecs[6] = '{cfg: 2, gap: 0, noisy: 1, rows: 2};
    clr_mon(0);
    tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_h_ready", 128'(h_in_ready), 128'(0));
    chk("rst_a_ready", 128'(alpha_in_ready), 128'(0));
    chk("rst_h_tvalid", 128'(core_H_row_tvalid), 128'(0));
    chk("rst_a_tvalid", 128'(core_alpha_tvalid), 128'(0));
    chk("rst_a_tlast", 128'(core_alpha_tlast), 128'(0));
    chk("rst_b_valid", 128'(beta_out_valid), 128'(0));
    chk("rst_b_last", 128'(beta_out_last), 128'(0));
    chk("rst_spurious", 128'(spurious_beta), 128'(0));
    chk("rst_timeout", 128'(timeout_err), 128'(0));
    chk("rst_h_row", 128'(core_H_row), 128'(0));
    chk("rst_alpha", 128'(core_alpha), 128'(0));
    chk("rst_beta", 128'(beta_out), 128'(0));
    chk("rst_beta_row", 128'(beta_out_row), 128'(0));
    rst_n = 1'b1;
    tick();
    for (int v = 0; v < 7; v++) run_frame(vecs[v].cfg, vecs[v].gap, vecs[v].noisy, vecs[v].rows);
    // abort in SEND_A after beat 0
    clr_mon(2);
    cfg_rows = RW'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_h(0);
    send_a(0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 128'(busy), 128'(0));
    chk("abort_a_ready", 128'(alpha_in_ready), 128'(0));
    repeat (4) tick();
    chk("abort_no_tlast", 128'(tl), 128'(0));
    chk("abort_no_done", 128'(dc), 128'(0));
    run_frame(1, 0, 0, 1);
    // abort and start together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_idle", 128'(busy), 128'(0));
    chk("abort_start_h_ready", 128'(h_in_ready), 128'(0));
    // beta during LOAD_H is dropped and sticky
    clr_mon(1);
    cfg_rows = RW'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    core_beta = b_val(9);
    core_beta_tvalid = 1'b1;
    tick();
    core_beta_tvalid = 1'b0;
    tick();
    chk("spur_no_beta", 128'(mb), 128'(0));
    chk("spur_set", 128'(spurious_beta), 128'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("spur_sticky", 128'(spurious_beta), 128'(1));
    run_frame(1, 0, 0, 1);
    chk("spur_cleared", 128'(spurious_beta), 128'(0));
    // reset in the middle of a frame
    clr_mon(2);
    cfg_rows = RW'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_h(0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_a_ready", 128'(alpha_in_ready), 128'(0));
    chk("midrst_h_tvalid", 128'(core_H_row_tvalid), 128'(0));
    #1 rst_n = 1'b1;
    tick();
    run_frame(2, 0, 0, 2);
`ifdef CAL_SCHED_TIMEOUT_EN
    clr_mon(1);
    cfg_rows = RW'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_h(0);
    for (int b = 0; b < A; b++) send_a(b);
    repeat (TO - 1) tick();
    chk("to_not_yet", 128'(timeout_err), 128'(0));
    chk("to_still_busy", 128'(busy), 128'(1));
    tick();
    chk("to_set", 128'(timeout_err), 128'(1));
    chk("to_idle", 128'(busy), 128'(0));
    repeat (3) tick();
    chk("to_no_done", 128'(dc), 128'(0));
    chk("to_sticky", 128'(timeout_err), 128'(1));
    run_frame(1, 0, 0, 1);
    chk("to_cleared", 128'(timeout_err), 128'(0));
`else
    chk("to_tied_low", 128'(timeout_err), 128'(0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
